query_row_buffer_scheduler: RTL and testbench

// - Sequences the two-bank query row RAM between the aggregator and the patch datapath.
// - Write side: fills one bank from the aggregator stream.
// - Read side: drains the other full bank, in address order, into a credit-controlled output FIFO.
// - Banks ping-pong, so row N+1 loads while row N is consumed.

---
 rtl/query_row_buffer_scheduler.sv | 249 ++++++++++++++++++++++++
 tb/tb_query_row_buffer_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_row_buffer_scheduler.sv
// Ping-pong scheduler for the two-bank query row RAM: the aggregator stream fills one bank
// while the other, full bank is read out in address order into a credit-controlled output FIFO.
module query_row_buffer_scheduler #(
  parameter int DATA_WIDTH   = 11,
  parameter int ADDR_WIDTH   = 7,
  parameter int ROW_LEN      = 128,
  parameter int READ_LATENCY = 2,
  parameter int OUT_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fsm_enable,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  ram_wen,
  output logic                  ram_wbank,
  output logic [ADDR_WIDTH-1:0] ram_wadr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_ren,
  output logic                  ram_rbank,
  output logic [ADDR_WIDTH-1:0] ram_radr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            bank_full,
  output logic [15:0]           rows_done
);

  localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int INF_W = $clog2(READ_LATENCY + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADR = ADDR_WIDTH'(ROW_LEN - 1);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_t;

  // ---------------------------------------------------------------- write side
  logic                  wbank_reg;
  logic [ADDR_WIDTH-1:0] wcount_reg;
  logic                  ram_wen_reg;
  logic                  ram_wbank_reg;
  logic [ADDR_WIDTH-1:0] ram_wadr_reg;
  logic [DATA_WIDTH-1:0] ram_wdata_reg;
  logic [1:0]            bank_open;
  logic [1:0]            bank_ready;
  logic                  accept;
  logic                  row_written;

  assign in_ready    = !rst && fsm_enable && bank_open[wbank_reg];
  assign accept      = in_valid && in_ready;
  assign row_written = accept && (wcount_reg == LAST_ADR);

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank_reg     <= 1'b0;
      wcount_reg    <= '0;
      ram_wen_reg   <= 1'b0;
      ram_wbank_reg <= 1'b0;
      ram_wadr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      ram_wen_reg <= accept;
      if (accept) begin
        ram_wbank_reg <= wbank_reg;
        ram_wadr_reg  <= wcount_reg;
        ram_wdata_reg <= in_data;
        if (row_written) begin
          wcount_reg <= '0;
          wbank_reg  <= ~wbank_reg;
        end else begin
          wcount_reg <= wcount_reg + 1'b1;
        end
      end
    end
  end

  assign ram_wen   = ram_wen_reg;
  assign ram_wbank = ram_wbank_reg;
  assign ram_wadr  = ram_wadr_reg;
  assign ram_wdata = ram_wdata_reg;

  // ---------------------------------------------------------------- read FSM
  rd_state_t             rd_state_reg, rd_state_next;
  logic                  rbank_reg, rbank_next;
  logic [ADDR_WIDTH-1:0] rcount_reg, rcount_next;
  logic [15:0]           rows_done_reg, rows_done_next;
  logic                  issue;
  logic                  drain_start;
  logic                  drain_done;
  logic                  credit_ok;
  logic [INF_W-1:0]      inflight;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_reg  <= R_IDLE;
      rbank_reg     <= 1'b0;
      rcount_reg    <= '0;
      rows_done_reg <= '0;
    end else begin
      rd_state_reg  <= rd_state_next;
      rbank_reg     <= rbank_next;
      rcount_reg    <= rcount_next;
      rows_done_reg <= rows_done_next;
    end
  end

  always_comb begin
    rd_state_next  = rd_state_reg;
    rbank_next     = rbank_reg;
    rcount_next    = rcount_reg;
    rows_done_next = rows_done_reg;
    issue          = 1'b0;
    drain_start    = 1'b0;
    drain_done     = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        if (bank_ready[rbank_reg]) begin
          drain_start   = 1'b1;
          rd_state_next = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          // rcount holds at the last address so ram_radr never leaves the row
          if (rcount_reg == LAST_ADR) rd_state_next = R_DRAIN;
          else                        rcount_next   = rcount_reg + 1'b1;
        end
      end
      R_DRAIN: begin
        if (inflight == '0) begin
          drain_done     = 1'b1;
          rbank_next     = ~rbank_reg;
          rcount_next    = '0;
          rows_done_next = rows_done_reg + 16'd1;
          rd_state_next  = R_IDLE;
        end
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign ram_ren   = issue;
  assign ram_rbank = rbank_reg;
  assign ram_radr  = rcount_reg;
  assign rows_done = rows_done_reg;

  // ---------------------------------------------------------------- bank states
  // Write side only moves EMPTY/FILLING banks and read side only FULL/DRAINING ones,
  // so the two update sources never target the same bank in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      bank_state_t state_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= B_EMPTY;
        end else if (accept && (wbank_reg == 1'(gi))) begin
          state_reg <= row_written ? B_FULL : B_FILLING;
        end else if (drain_start && (rbank_reg == 1'(gi))) begin
          state_reg <= B_DRAINING;
        end else if (drain_done && (rbank_reg == 1'(gi))) begin
          state_reg <= B_EMPTY;
        end
      end

      assign bank_open[gi]  = (state_reg == B_EMPTY) || (state_reg == B_FILLING);
      assign bank_ready[gi] = (state_reg == B_FULL);
      assign bank_full[gi]  = (state_reg == B_FULL) || (state_reg == B_DRAINING);
    end
  endgenerate

  // ---------------------------------------------------------------- return path
  logic [READ_LATENCY-1:0] sr_valid_reg;
  logic [READ_LATENCY-1:0] sr_last_reg;
  logic                    push;
  logic                    push_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_valid_reg <= '0;
      sr_last_reg  <= '0;
    end else begin
      sr_valid_reg[0] <= issue;
      sr_last_reg[0]  <= issue && (rcount_reg == LAST_ADR);
      for (int i = 1; i < READ_LATENCY; i++) begin
        sr_valid_reg[i] <= sr_valid_reg[i-1];
        sr_last_reg[i]  <= sr_last_reg[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + INF_W'(sr_valid_reg[i]);
    end
  end

  assign push      = sr_valid_reg[READ_LATENCY-1];
  assign push_last = sr_last_reg[READ_LATENCY-1];

  // ---------------------------------------------------------------- output FIFO
  logic [DATA_WIDTH:0] fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    fifo_count_reg;
  logic                pop;
  logic [OCC_W-1:0]    occupancy;

  // Reads in flight already own a FIFO slot, so issuing against this sum cannot overflow.
  assign occupancy = OCC_W'(fifo_count_reg) + OCC_W'(inflight);
  assign credit_ok = occupancy < OCC_W'(OUT_DEPTH);
  assign out_valid = (fifo_count_reg != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? fifo_mem[rd_ptr_reg][DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid && fifo_mem[rd_ptr_reg][DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {push_last, ram_rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      assert (!(push && !pop && (fifo_count_reg == CNT_W'(OUT_DEPTH))));
      if (push) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_query_row_buffer_scheduler.sv
// Directed bench for query_row_buffer_scheduler with an 8-word row and a 2-cycle RAM model.
module tb_query_row_buffer_scheduler;

  localparam int DW    = 11;
  localparam int AW    = 4;
  localparam int ROW   = 8;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fsm_enable = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ram_wen, ram_wbank, ram_ren, ram_rbank;
  logic [AW-1:0] ram_wadr, ram_radr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  logic          out_valid, out_last;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    bank_full;
  logic [15:0]   rows_done;

  query_row_buffer_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ROW_LEN(ROW), .READ_LATENCY(LAT), .OUT_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .fsm_enable(fsm_enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_wen(ram_wen), .ram_wbank(ram_wbank), .ram_wadr(ram_wadr),
    .ram_wdata(ram_wdata), .ram_ren(ram_ren), .ram_rbank(ram_rbank), .ram_radr(ram_radr),
    .ram_rdata(ram_rdata), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .bank_full(bank_full), .rows_done(rows_done)
  );

  always #5 clk = ~clk;

  // Two-bank RAM model with LAT cycles from ram_ren to ram_rdata
  logic [DW-1:0] ram_mem [2][2**AW];
  logic [DW-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    if (ram_wen) ram_mem[ram_wbank][ram_wadr] <= ram_wdata;
    rd_pipe[0] <= ram_ren ? ram_mem[ram_rbank][ram_radr] : '1;
    for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign ram_rdata = rd_pipe[LAT-1];

  typedef struct {int cyc; int bank; int adr; int data;} wr_t;
  wr_t wlog[$];
  wr_t wentry;
  int  got_data[$];
  int  got_last[$];
  int  n_assert = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  issued = 0;
  int  popped = 0;
  int  max_out = 0;
  bit  rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (ram_wen) begin
        wentry.cyc = cyc; wentry.bank = int'(ram_wbank);
        wentry.adr = int'(ram_wadr); wentry.data = int'(ram_wdata);
        wlog.push_back(wentry);
      end
      if (ram_ren) issued++;
      if (out_valid && out_ready) begin
        got_data.push_back(int'(out_data));
        got_last.push_back(int'(out_last));
        popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input int w);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_data  = DW'(w);
    while (!hs && n < 300) begin
      @(negedge clk);
      hs = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check($sformatf("accept_%0d", w), 32'(hs), 32'd1);
  endtask

  task automatic wait_outputs(input int n);
    int k = 0;
    while (got_data.size() < n && k < 600) begin
      tick();
      k++;
    end
    repeat (4) tick();
    check("out_count", got_data.size(), n);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (bank_full != 2'b00 && k < 100) begin
      tick();
      k++;
    end
    check("bank_full_idle", 32'(bank_full), 32'd0);
  endtask

  task automatic check_row_out(input int base, input int step, input int n);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("out_data_%0d", i), got_data[i], (base + i * step) % 2048);
      check($sformatf("out_last_%0d", i), got_last[i], ((i % ROW) == ROW - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int nr;
    int nw;
    bit found;

    // ---------------- reset
    fsm_enable = 1'b1;
    repeat (2) tick();
    check("in_ready_in_rst", 32'(in_ready), 32'd0);
    check("outs_in_rst", {ram_wen, ram_ren, out_valid, bank_full, rows_done}, 32'd0);
    rst = 1'b0;
    fsm_enable = 1'b0;
    tick();
    check("in_ready_enable_low", 32'(in_ready), 32'd0);
    check("outs_after_rst", {ram_wen, ram_ren, out_valid, out_last, out_data, bank_full}, 32'd0);
    fsm_enable = 1'b1;
    #1;
    check("in_ready_enabled", 32'(in_ready), 32'd1);

    // ---------------- fill and drain of bank 0
    out_ready = 1'b1;
    wlog.delete();
    for (int i = 0; i < ROW; i++) send(i);
    check("fill_bank_full", 32'(bank_full), 32'b01);
    check("fill_ren_not_yet", 32'(ram_ren), 32'd0);
    tick();
    check("first_ren", {ram_ren, ram_rbank, 28'(ram_radr)}, {1'b1, 1'b0, 28'd0});
    check("fill_wlog_size", wlog.size(), ROW);
    for (int i = 0; i < ROW && i < wlog.size(); i++) begin
      check($sformatf("fill_wr_%0d", i), {wlog[i].bank[7:0], wlog[i].adr[7:0], wlog[i].data[15:0]},
            {8'd0, 8'(i), 16'(i)});
      check($sformatf("fill_cyc_%0d", i), wlog[i].cyc - wlog[0].cyc, i);
    end
    wait_outputs(ROW);
    check_row_out(0, 1, ROW);
    wait_idle();
    check("rows_done_1", 32'(rows_done), 32'd1);

    // ---------------- ping-pong with consumer stalled
    out_ready = 1'b0;
    got_data.delete(); got_last.delete(); wlog.delete();
    issued = 0; popped = 0; max_out = 0;
    for (int i = 0; i < 16; i++) send(i);
    check("pp_both_full", 32'(bank_full), 32'b11);
    in_valid = 1'b1;
    in_data  = DW'(16);
    nr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) nr++;
      tick();
    end
    check("pp_in_ready_low", nr, 0);
    check("pp_fifo_head", {out_valid, 31'(out_data)}, {1'b1, 31'd0});
    check("pp_no_output", got_data.size(), 0);
    check("pp_fifo_words", issued, DEPTH);
    out_ready = 1'b1;
    for (int i = 16; i < 24; i++) send(i);
    check("pp_word16_wr", {wlog[16].bank[15:0], wlog[16].adr[15:0]}, {16'd1, 16'd0});
    wait_outputs(24);
    check_row_out(0, 1, 24);
    wait_idle();
    check("pp_rows_done", 32'(rows_done), 32'd4);
    check("pp_max_outstanding", max_out, DEPTH);

    // ---------------- random back-pressure, 10 rows
    got_data.delete(); got_last.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 10 * ROW; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      send(i * 3 + 5);
    end
    wait_outputs(10 * ROW);
    check_row_out(5, 3, 10 * ROW);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    wait_idle();
    check("rand_rows_done", 32'(rows_done), 32'd14);

    // ---------------- fsm_enable gap after word 3
    got_data.delete(); got_last.delete(); wlog.delete();
    for (int i = 0; i < 4; i++) send(300 + i);
    fsm_enable = 1'b0;
    in_valid   = 1'b1;
    in_data    = DW'(304);
    nr = 0; nw = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) nr++;
      if (ram_wen && k > 0) nw++;
      tick();
    end
    check("gap_in_ready", nr, 0);
    check("gap_wen", nw, 0);
    fsm_enable = 1'b1;
    for (int i = 4; i < ROW; i++) send(300 + i);
    check("gap_resume_wr", {wlog[4].adr[15:0], wlog[4].data[15:0]}, {16'd4, 16'd304});
    check("gap_resume_late", 32'(wlog[4].cyc - wlog[3].cyc >= 20), 32'd1);
    wait_outputs(ROW);
    check_row_out(300, 1, ROW);
    wait_idle();
    check("gap_rows_done", 32'(rows_done), 32'd15);

    // ---------------- reset mid-drain at rcount 3
    got_data.delete(); got_last.delete();
    for (int i = 0; i < ROW; i++) send(500 + i);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (ram_ren && ram_radr == AW'(3)) found = 1'b1;
      else tick();
    end
    check("mid_found_rcount3", {31'(ram_radr), ram_ren}, {31'd3, 1'b1});
    rst = 1'b1;
    #1;
    check("mid_in_ready_rst", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    check("mid_ctrl_zero", {ram_wen, ram_ren, out_valid, out_last, bank_full, rows_done}, 32'd0);
    check("mid_bus_zero", {ram_wbank, ram_rbank, ram_wadr, ram_radr, out_data}, 32'd0);
    got_data.delete(); got_last.delete(); wlog.delete();
    issued = 0; popped = 0;
    for (int i = 0; i < ROW; i++) send(100 + i);
    for (int i = 0; i < ROW && i < wlog.size(); i++) begin
      check($sformatf("fresh_wr_%0d", i), {wlog[i].bank[15:0], wlog[i].adr[15:0]}, {16'd0, 16'(i)});
    end
    wait_outputs(ROW);
    check_row_out(100, 1, ROW);
    wait_idle();
    check("fresh_rows_done", 32'(rows_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
